// File: rtl/mma_tile_stream_adapter_if.sv
// Tile/stream bundle shared by the interconnect stream, the adapter and the MMA core.
// The c_zero_i member exists only when MMA_ADAPTER_CZERO_EN is defined.
interface mma_tile_stream_adapter_if #(
   parameter int M = 8,
   parameter int N = 4,
   parameter int K = 16,
   parameter int P = 8
);
   localparam int AW    = 4 * P;
   localparam int BEATW = (K * P > AW * N) ? K * P : AW * N;

   logic                               s_valid_i;
   logic                               s_ready_o;
   logic [BEATW-1:0]                   s_data_i;
   logic signed [M-1:0][K-1:0][P-1:0]  a_o;
   logic signed [K-1:0][N-1:0][P-1:0]  b_o;
   logic signed [M-1:0][N-1:0][AW-1:0] c_o;
   logic                               tile_valid_o;
   logic                               tile_ready_i;
   logic signed [M-1:0][N-1:0][AW-1:0] d_i;
   logic                               d_valid_i;
   logic                               d_ready_o;
   logic                               m_valid_o;
   logic                               m_ready_i;
   logic [N*AW-1:0]                    m_data_o;
   logic                               m_last_o;
`ifdef MMA_ADAPTER_CZERO_EN
   logic                               c_zero_i;
`endif

   modport slave (
`ifdef MMA_ADAPTER_CZERO_EN
      input  c_zero_i,
`endif
      input  s_valid_i, s_data_i, tile_ready_i, d_i, d_valid_i, m_ready_i,
      output s_ready_o, a_o, b_o, c_o, tile_valid_o, d_ready_o, m_valid_o, m_data_o, m_last_o
   );

   modport master (
`ifdef MMA_ADAPTER_CZERO_EN
      output c_zero_i,
`endif
      output s_valid_i, s_data_i, tile_ready_i, d_i, d_valid_i, m_ready_i,
      input  s_ready_o, a_o, b_o, c_o, tile_valid_o, d_ready_o, m_valid_o, m_data_o, m_last_o
   );
endinterface

// File: rtl/mma_tile_stream_adapter.sv
// Deserialises row beats into A/B/C tiles for the MMA and serialises D tiles back to rows.
// Define MMA_ADAPTER_CZERO_EN to allow skipping the C load with c_zero_i (C becomes all zero).
module mma_tile_stream_adapter #(
   parameter int M = 8,
   parameter int N = 4,
   parameter int K = 16,
   parameter int P = 8
) (
   input logic                     clk_i,
   input logic                     rst_i,
   mma_tile_stream_adapter_if.slave bus
);
   localparam int AW = 4 * P;
   localparam int MW = $clog2(M);
   localparam int KW = $clog2(K);
   localparam int RW = (MW > KW) ? MW : KW;
   localparam logic [RW-1:0] M_LAST  = RW'(M - 1);
   localparam logic [RW-1:0] K_LAST  = RW'(K - 1);
   localparam logic [RW-1:0] ROW_ONE = RW'(1);
   localparam logic [MW-1:0] D_LAST  = MW'(M - 1);
   localparam logic [MW-1:0] IDX_ONE = MW'(1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      LOAD_C = 2'd2,
      ISSUE  = 2'd3
   } load_state_e;

   typedef enum logic {
      D_IDLE = 1'b0,
      DRAIN  = 1'b1
   } drain_state_e;

   load_state_e                        load_r;
   load_state_e                        load_nx_s;
   logic [RW-1:0]                      row_r;
   logic [RW-1:0]                      row_nx_s;
   logic                               s_ready_r;
   logic                               tile_valid_r;
   logic                               beat_s;
   logic                               issue_s;
   logic                               skip_c_s;
   logic signed [M-1:0][K-1:0][P-1:0]  a_r;
   logic signed [K-1:0][N-1:0][P-1:0]  b_r;
   logic signed [M-1:0][N-1:0][AW-1:0] c_r;

   drain_state_e                       drain_r;
   drain_state_e                       drain_nx_s;
   logic [MW-1:0]                      idx_r;
   logic [MW-1:0]                      idx_nx_s;
   logic signed [M-1:0][N-1:0][AW-1:0] d_r;
   logic                               d_ready_r;
   logic                               m_valid_r;
   logic                               m_last_r;
   logic [N*AW-1:0]                    m_data_r;
   logic                               d_take_s;
   logic                               m_take_s;

   assign beat_s   = bus.s_valid_i & s_ready_r;
   assign issue_s  = tile_valid_r & bus.tile_ready_i;
   assign d_take_s = bus.d_valid_i & d_ready_r;
   assign m_take_s = m_valid_r & bus.m_ready_i;

`ifdef MMA_ADAPTER_CZERO_EN
   logic czero_r;

   // c_zero_i travels with A row 0 and decides whether this tile loads C at all
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         czero_r <= 1'b0;
      end else if ((load_r == LOAD_A) && beat_s && (row_r == '0)) begin
         czero_r <= bus.c_zero_i;
      end
   end

   assign skip_c_s = czero_r;
`else
   assign skip_c_s = 1'b0;
`endif

   // Load FSM next state; one row counter walks A, then B, then C
   always_comb begin
      load_nx_s = load_r;
      row_nx_s  = row_r;
      case (load_r)
         LOAD_A: begin
            if (beat_s && (row_r == M_LAST)) begin
               load_nx_s = LOAD_B;
               row_nx_s  = '0;
            end else if (beat_s) begin
               row_nx_s  = row_r + ROW_ONE;
            end else begin
               row_nx_s  = row_r;
            end
         end
         LOAD_B: begin
            if (beat_s && (row_r == K_LAST)) begin
               load_nx_s = skip_c_s ? ISSUE : LOAD_C;
               row_nx_s  = '0;
            end else if (beat_s) begin
               row_nx_s  = row_r + ROW_ONE;
            end else begin
               row_nx_s  = row_r;
            end
         end
         LOAD_C: begin
            if (beat_s && (row_r == M_LAST)) begin
               load_nx_s = ISSUE;
               row_nx_s  = '0;
            end else if (beat_s) begin
               row_nx_s  = row_r + ROW_ONE;
            end else begin
               row_nx_s  = row_r;
            end
         end
         ISSUE: begin
            if (issue_s) begin
               load_nx_s = LOAD_A;
               row_nx_s  = '0;
            end else begin
               load_nx_s = ISSUE;
            end
         end
         default: begin
            load_nx_s = LOAD_A;
            row_nx_s  = '0;
         end
      endcase
   end

   // Load FSM state; ready/valid are derived from the next state so they stay registered
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         load_r       <= LOAD_A;
         row_r        <= '0;
         s_ready_r    <= 1'b0;
         tile_valid_r <= 1'b0;
      end else begin
         load_r       <= load_nx_s;
         row_r        <= row_nx_s;
         s_ready_r    <= (load_nx_s != ISSUE);
         tile_valid_r <= (load_nx_s == ISSUE);
      end
   end

   // Single-buffered tile storage, written one row per accepted beat
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_r <= '0;
         b_r <= '0;
         c_r <= '0;
      end else if (beat_s) begin
         case (load_r)
            LOAD_A: a_r[row_r[MW-1:0]] <= bus.s_data_i[K*P-1:0];
            LOAD_B: begin
               b_r[row_r[KW-1:0]] <= bus.s_data_i[N*P-1:0];
               if ((row_r == K_LAST) && skip_c_s) begin
                  c_r <= '0;
               end
            end
            LOAD_C: c_r[row_r[MW-1:0]] <= bus.s_data_i[N*AW-1:0];
            default: a_r <= a_r;
         endcase
      end
   end

   // Drain FSM next state, independent of the load side
   always_comb begin
      drain_nx_s = drain_r;
      idx_nx_s   = idx_r;
      case (drain_r)
         D_IDLE: begin
            if (d_take_s) begin
               drain_nx_s = DRAIN;
               idx_nx_s   = '0;
            end else begin
               drain_nx_s = D_IDLE;
            end
         end
         DRAIN: begin
            if (m_take_s && (idx_r == D_LAST)) begin
               drain_nx_s = D_IDLE;
            end else if (m_take_s) begin
               idx_nx_s   = idx_r + IDX_ONE;
            end else begin
               idx_nx_s   = idx_r;
            end
         end
         default: begin
            drain_nx_s = D_IDLE;
            idx_nx_s   = '0;
         end
      endcase
   end

   // Drain state, captured D tile and registered row outputs (the row reloads unchanged on a stall)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drain_r   <= D_IDLE;
         idx_r     <= '0;
         d_r       <= '0;
         d_ready_r <= 1'b0;
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
         m_data_r  <= '0;
      end else begin
         drain_r   <= drain_nx_s;
         idx_r     <= idx_nx_s;
         d_ready_r <= (drain_nx_s == D_IDLE);
         m_valid_r <= (drain_nx_s == DRAIN);
         m_last_r  <= (drain_nx_s == DRAIN) && (idx_nx_s == D_LAST);
         if (d_take_s) begin
            d_r <= bus.d_i;
         end
         if (drain_nx_s == DRAIN) begin
            m_data_r <= d_take_s ? bus.d_i[idx_nx_s] : d_r[idx_nx_s];
         end
      end
   end

   assign bus.s_ready_o    = s_ready_r;
   assign bus.tile_valid_o = tile_valid_r;
   assign bus.a_o          = a_r;
   assign bus.b_o          = b_r;
   assign bus.c_o          = c_r;
   assign bus.d_ready_o    = d_ready_r;
   assign bus.m_valid_o    = m_valid_r;
   assign bus.m_last_o     = m_last_r;
   assign bus.m_data_o     = m_data_r;
endmodule

// File: tb/tb_mma_tile_stream_adapter.sv
// Directed and randomized bench for mma_tile_stream_adapter against a tile/row reference model.
// Covers the MMA_ADAPTER_CZERO_EN path when that macro is defined.
module tb_mma_tile_stream_adapter;
   localparam int M = 8;
   localparam int N = 4;
   localparam int K = 16;
   localparam int P = 8;
   localparam int AW = 4 * P;
   localparam int BEATW = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mma_tile_stream_adapter_if #(.M(M), .N(N), .K(K), .P(P)) ifc ();
   mma_tile_stream_adapter #(.M(M), .N(N), .K(K), .P(P)) dut (.clk_i(clk), .rst_i(rst), .bus(ifc));

   int total = 0;
   int bad   = 0;
   int ma[M][K];
   int mb[K][N];
   int mc[M][N];
   int md[M][N];
   logic [N*AW:0] got[$];

   // output-stream monitor: records {last,row} for every row handshake
   always @(negedge clk) begin
      if (!rst && ifc.m_valid_o && ifc.m_ready_i) got.push_back({ifc.m_last_o, ifc.m_data_o});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_tile(input string tag, input logic [1023:0] obs, input logic [1023:0] exp, input int ew);
      int fi = 0;
      logic [1023:0] mask = (1024'(1) << ew) - 1024'(1);
      for (int e = 1024 / ew - 1; e >= 0; e--)
         if (((obs >> (e * ew)) & mask) !== ((exp >> (e * ew)) & mask)) fi = e;
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: element %0d observed=%0h expected=%0h", tag, fi,
                32'((obs >> (fi * ew)) & mask), 32'((exp >> (fi * ew)) & mask));
      end
   endtask

   function automatic logic [BEATW-1:0] beat_a(int i);
      logic [BEATW-1:0] v = '0;
      for (int k = 0; k < K; k++) v[k*P +: P] = 8'(ma[i][k]);
      return v;
   endfunction

   function automatic logic [BEATW-1:0] beat_b(int k);
      logic [BEATW-1:0] v = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int j = 0; j < N; j++) v[j*P +: P] = 8'(mb[k][j]);
      return v;
   endfunction

   function automatic logic [BEATW-1:0] beat_c(int i);
      logic [BEATW-1:0] v = '0;
      for (int j = 0; j < N; j++) v[j*AW +: AW] = 32'(mc[i][j]);
      return v;
   endfunction

   function automatic logic [1023:0] exp_a();
      logic [1023:0] v = '0;
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) v[(i*K+k)*P +: P] = 8'(ma[i][k]);
      return v;
   endfunction

   function automatic logic [1023:0] exp_b();
      logic [1023:0] v = '0;
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) v[(k*N+j)*P +: P] = 8'(mb[k][j]);
      return v;
   endfunction

   function automatic logic [1023:0] exp_c();
      logic [1023:0] v = '0;
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) v[(i*N+j)*AW +: AW] = 32'(mc[i][j]);
      return v;
   endfunction

   function automatic logic [N*AW-1:0] exp_row(int r);
      logic [N*AW-1:0] v = '0;
      for (int j = 0; j < N; j++) v[j*AW +: AW] = 32'(md[r][j]);
      return v;
   endfunction

   task automatic rand_tile();
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = int'($urandom());
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = int'($urandom());
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) mc[i][j] = int'($urandom());
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) md[i][j] = int'($urandom());
   endtask

   task automatic send_beat(input logic [BEATW-1:0] data);
      logic acc = 1'b0;
      ifc.s_valid_i = 1'b1;
      ifc.s_data_i  = data;
      for (int c = 0; c < 60 && !acc; c++) begin
         acc = ifc.s_ready_o;
         @(posedge clk); #1;
      end
      ifc.s_valid_i = 1'b0;
      check("s_beat_accept", acc, 1);
   endtask

   task automatic load_tile(input bit gaps, input int nc);
      for (int r = 0; r < M + K + nc; r++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         if (r < M) send_beat(beat_a(r));
         else if (r < M + K) send_beat(beat_b(r - M));
         else send_beat(beat_c(r - M - K));
      end
   endtask

   task automatic check_full_tile(input string tag);
      check({tag, "_valid"}, {ifc.tile_valid_o, ifc.s_ready_o}, 2'b10);
      check_tile({tag, "_a"}, ifc.a_o, exp_a(), P);
      check_tile({tag, "_b"}, {512'b0, ifc.b_o}, exp_b(), P);
      check_tile({tag, "_c"}, ifc.c_o, exp_c(), AW);
   endtask

   task automatic issue_tile(output int n);
      logic hs = 1'b0;
      n = 0;
      ifc.tile_ready_i = 1'b1;
      while (!hs && n < 100) begin
         hs = ifc.tile_valid_o;
         @(posedge clk); #1;
         n++;
      end
      ifc.tile_ready_i = 1'b0;
      check("tile_handshake", hs, 1);
      check("after_issue", {ifc.tile_valid_o, ifc.s_ready_o}, 2'b01);
   endtask

   task automatic send_d();
      logic [1023:0] v = '0;
      logic hs = 1'b0;
      for (int r = 0; r < M; r++) for (int j = 0; j < N; j++) v[(r*N+j)*AW +: AW] = 32'(md[r][j]);
      ifc.d_i = v;
      ifc.d_valid_i = 1'b1;
      for (int c = 0; c < 100 && !hs; c++) begin
         hs = ifc.d_ready_o;
         @(posedge clk); #1;
      end
      ifc.d_valid_i = 1'b0;
      check("d_handshake", hs, 1);
   endtask

   task automatic drain_random();
      int c = 0;
      send_d();
      while (got.size() < M && c < 400) begin
         ifc.m_ready_i = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
         c++;
      end
      ifc.m_ready_i = 1'b0;
      check("drain_count", got.size(), M);
      check("drain_idle", {ifc.d_ready_o, ifc.m_valid_o}, 2'b10);
   endtask

   task automatic compare_rows(input string tag);
      for (int r = 0; r < M; r++)
         check($sformatf("%s_row%0d", tag, r), (got.size() > r) ? got[r] : 'x, {(r == M - 1), exp_row(r)});
      check({tag, "_rowcount"}, got.size(), M);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {ifc.s_ready_o, ifc.tile_valid_o, ifc.d_ready_o, ifc.m_valid_o, ifc.m_last_o}, 5'b0);
      check({tag, "_mdata"}, ifc.m_data_o, 0);
      check_tile({tag, "_a"}, ifc.a_o, '0, P);
      check_tile({tag, "_b"}, {512'b0, ifc.b_o}, '0, P);
      check_tile({tag, "_c"}, ifc.c_o, '0, AW);
   endtask

   initial begin
      int n;
      int errs;
      int drerr;
      int k;
      ifc.s_valid_i = 1'b0;
      ifc.s_data_i = '0;
      ifc.tile_ready_i = 1'b0;
      ifc.d_i = '0;
      ifc.d_valid_i = 1'b0;
      ifc.m_ready_i = 1'b0;
`ifdef MMA_ADAPTER_CZERO_EN
      ifc.c_zero_i = 1'b0;
`endif
      // reset values, then both readies rise one edge after release
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_reset", {ifc.s_ready_o, ifc.d_ready_o}, 2'b11);

      // directed single tile: A=i+k, B=k-j, C=100
      for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) ma[i][kk] = i + kk;
      for (int kk = 0; kk < K; kk++) for (int j = 0; j < N; j++) mb[kk][j] = kk - j;
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) mc[i][j] = 100;
      load_tile(1'b0, M - 1);
      check("beat31_not_valid", {ifc.tile_valid_o, ifc.s_ready_o}, 2'b01);
      send_beat(beat_c(M - 1));
      check("a35", {ifc.a_o[3][5]}, 8);
      check("b23", {ifc.b_o[2][3]}, 8'hff);
      check("c73", {ifc.c_o[7][3]}, 100);
      check_full_tile("tile1");

      // tile backpressure while the source toggles valid
      errs = 0;
      for (int c = 0; c < 10; c++) begin
         ifc.s_valid_i = c[0];
         ifc.s_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(posedge clk); #1;
         if (ifc.s_ready_o !== 1'b0 || ifc.tile_valid_o !== 1'b1) errs++;
      end
      ifc.s_valid_i = 1'b0;
      check("stall_ready_valid", errs, 0);
      check_full_tile("stall");
      issue_tile(n);
      check("issue_cycles", n, 1);

      // directed drain D[r][j]=r*16+j with m_ready 1,0,1,0...
      for (int r = 0; r < M; r++) for (int j = 0; j < N; j++) md[r][j] = r * 16 + j;
      got.delete();
      send_d();
      check("drain_first", {ifc.m_valid_o, ifc.d_ready_o, ifc.m_last_o, ifc.m_data_o}, {3'b100, exp_row(0)});
      errs = 0;
      drerr = 0;
      k = 0;
      for (int c = 0; c < 2 * M; c++) begin
         ifc.m_ready_i = (c % 2 == 0);
         if (ifc.m_valid_o && (ifc.m_data_o !== exp_row(k) || ifc.m_last_o !== (k == M - 1))) errs++;
         if (ifc.m_valid_o && ifc.m_ready_i) k++;
         @(posedge clk); #1;
         if (ifc.d_ready_o !== (k == M)) drerr++;
      end
      ifc.m_ready_i = 1'b0;
      check("drain_row_values", errs, 0);
      check("drain_d_ready", drerr, 0);
      check("drain_done_idle", {ifc.d_ready_o, ifc.m_valid_o}, 2'b10);
      compare_rows("drain");

      // reset after 5 A beats discards the partial tile
      rand_tile();
      for (int i = 0; i < 5; i++) send_beat({$urandom(), $urandom(), $urandom(), $urandom()});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero("midreset");
      @(posedge clk); #1;
      check("ready_after_midreset", {ifc.s_ready_o, ifc.d_ready_o}, 2'b11);
      load_tile(1'b0, M);
      check_full_tile("fresh");
      issue_tile(n);

`ifdef MMA_ADAPTER_CZERO_EN
      // C skipped when c_zero_i accompanies A row 0
      rand_tile();
      ifc.c_zero_i = 1'b1;
      send_beat(beat_a(0));
      ifc.c_zero_i = 1'b0;
      for (int i = 1; i < M; i++) send_beat(beat_a(i));
      for (int kk = 0; kk < K; kk++) send_beat(beat_b(kk));
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) mc[i][j] = 0;
      check_full_tile("czero");
      issue_tile(n);
      rand_tile();
      load_tile(1'b0, 0);
      check("czero_off_wait", {ifc.tile_valid_o, ifc.s_ready_o}, 2'b01);
      for (int i = 0; i < M; i++) send_beat(beat_c(i));
      check_full_tile("czero_off");
      issue_tile(n);
`endif

      // drain of tile n overlaps the load of tile n+1
      for (int t = 0; t < 4; t++) begin
         rand_tile();
         got.delete();
         fork
            begin
               load_tile(1'b1, M);
               check_full_tile($sformatf("conc%0d", t));
               issue_tile(n);
            end
            begin
               drain_random();
            end
         join
         compare_rows($sformatf("conc%0d", t));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mma_tile_stream_adapter.md
# mma_tile_stream_adapter

Stream-side adapter on both ends of the matrix-multiply-accumulate top level. On the producer side it deserialises a narrow row-per-beat stream into full A, B and C tiles, then offers them on a valid/ready tile interface. On the consumer side it accepts completed D tiles over the same valid/ready protocol and serialises them row by row onto an output stream. It sits between the system interconnect/DMA and the MMA top level, so the MMA core never has to see narrow transfers.

## Interface
- M, 8, rows of A, C and D
- N, 4, columns of B, C and D
- K, 16, inner dimension
- P, 8, element width in bits; accumulator width is 4*P
- BEATW, max(K*P, 4*P*N) (local, derived), input beat width
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input beat accepted
- s_data_i  in  BEATW  one matrix row per beat; element j at bits [j*W +: W], where W is P or 4*P
- a_o  out  signed [P-1:0] [M][K]  A tile to the MMA
- b_o  out  signed [P-1:0] [K][N]  B tile to the MMA
- c_o  out  signed [4P-1:0] [M][N]  C tile to the MMA
- tile_valid_o  out  1  A, B and C are valid
- tile_ready_i  in  1  MMA accepts the tile
- d_i  in  signed [4P-1:0] [M][N]  result tile from the MMA
- d_valid_i  in  1  result valid
- d_ready_o  out  1  result accepted
- m_valid_o  out  1  output row valid
- m_ready_i  in  1  output row accepted
- m_data_o  out  N*4P  one D row; element j at bits [j*4P +: 4P]
- m_last_o  out  1  marks the last row (row M-1) of a tile
- c_zero_i  in  1  present only when the macro in Configuration is defined

## Operation
- Load FSM states: LOAD_A, LOAD_B, LOAD_C, ISSUE. A single row counter is shared across the load states.
- A beat transfers when s_valid_i & s_ready_o are both high at a clock edge.
- s_ready_o is 1 in all LOAD_* states and 0 in ISSUE.
- LOAD_A: row r of A takes s_data_i[K*P-1:0]. After row M-1, clear the counter and go to LOAD_B.
- LOAD_B: row r of B takes s_data_i[N*P-1:0]. After row K-1, go to LOAD_C.
- LOAD_C: row r of C takes s_data_i[N*4P-1:0]. After row M-1, go to ISSUE.
- Beat bits above the width used in a phase are ignored.
- ISSUE: tile_valid_o=1. a_o, b_o and c_o hold stable until tile_valid_o & tile_ready_i, then go to LOAD_A with the counter at 0.
- The tile registers are single-buffered: no beat of the next tile is accepted until the current tile has been issued.
- Drain FSM states: D_IDLE, DRAIN. It runs independently of the load FSM.
- D_IDLE: d_ready_o=1. On d_valid_i & d_ready_o, capture the whole of d_i, set the row index to 0 and go to DRAIN.
- DRAIN: d_ready_o=0, m_valid_o=1, m_data_o = captured row idx, m_last_o = (idx==M-1).
- On m_valid_o & m_ready_i: increment idx. On the last row, return to D_IDLE.
- m_data_o is held stable while m_ready_i is low.
- No arithmetic is done on data: pure bit placement, no sign extension, no truncation.

## Timing
- Reset: every state register is cleared, and the load and drain FSMs go to LOAD_A and D_IDLE.
- Reset values of outputs: s_ready_o=0, tile_valid_o=0, d_ready_o=0, m_valid_o=0, m_last_o=0, a_o/b_o/c_o/m_data_o = 0.
- s_ready_o and d_ready_o are registered. Both rise on the first edge after rst_i is sampled low.
- Asserting rst_i mid-tile or mid-drain discards partial data. The next tile restarts at A row 0.
- Load latency: tile_valid_o rises on the cycle after the last C beat is accepted. A full-rate tile therefore takes 2M+K beats, plus 1 cycle to valid.
- s_ready_o drops on the same edge that accepts the last C beat.
- Back-to-back tiles: after the issue handshake, s_ready_o=1 in the next cycle. This gives 1 bubble per tile.
- Drain latency: m_valid_o rises on the cycle after the D handshake, and a full tile takes M beats.
- d_ready_o rises on the cycle after the last row handshake, so at most one D tile is in flight.
- No combinational path from any input to any output.
- Both interfaces follow the same protocol rule: valid, once raised, is not withdrawn before the handshake.

## Configuration
- MMA_ADAPTER_CZERO_EN defined:
  - Port c_zero_i exists and is sampled at the handshake of A row 0.
  - If that sample is 1, LOAD_C is skipped: LOAD_B row K-1 goes straight to ISSUE with all of c_o = 0.
- MMA_ADAPTER_CZERO_EN undefined:
  - Port c_zero_i is absent.
  - LOAD_C always runs, and every tile takes 2M+K beats.

## Test plan
- Single tile at defaults: A[i][k]=i+k, B[k][j]=k-j, C=100, then D captured.
  - Required: tile_valid_o rises after beat 32 is accepted, with a_o[3][5]=8, b_o[2][3]=-1 and c_o[7][3]=100.
  - Required: s_ready_o=0 until the tile handshake.
- Backpressure on the tile: hold tile_ready_i=0 for 10 cycles while toggling s_valid_i.
  - Required: no beats are accepted and a_o/b_o/c_o are unchanged. The tile handshake happens on the cycle tile_ready_i rises.
- Drain: D[r][j]=r*16+j, with m_ready_i toggling 1,0,1,0.
  - Required: 8 beats, m_data_o stable while stalled, m_last_o only with row 7, and d_ready_o=0 until the row-7 handshake.
- Reset mid-tile: rst_i high for 1 cycle after 5 A beats.
  - Required: all outputs go to 0. After reset, 32 fresh beats produce a tile containing only the new data.
- MMA_ADAPTER_CZERO_EN with c_zero_i=1 on A row 0.
  - Required: tile_valid_o after 24 beats with all of c_o = 0. The next tile, with c_zero_i=0, needs 32 beats.
- Concurrency: the drain of tile n overlaps the load of tile n+1.
  - Required: both complete, with no beat lost or duplicated on either stream.
